// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC and PC-sequencer state encoding.
package cpu_pkg;

  localparam int unsigned PC_ADDR_W   = 16;
  localparam int unsigned PC_DISP_W   = 8;
  localparam int unsigned PC_RESET_PC = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } pc_state_t;

endpackage : cpu_pkg

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential increment and jump/branch target select.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_W,
  parameter int DISP_W = PC_DISP_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  input  logic [DISP_W-1:0] disp,
  input  logic              cond_true,
  input  logic              br_rel,
  output logic [ADDR_W-1:0] pc_inc,
  output logic [ADDR_W-1:0] tgt_next
);

  logic [ADDR_W-1:0] disp_sx;

  // Increment, sign-extended displacement and taken/not-taken target select.
  always_comb begin
    disp_sx  = {{(ADDR_W-DISP_W){disp[DISP_W-1]}}, disp};
    pc_inc   = pc + ADDR_W'(1);
    tgt_next = pc_inc;
    if (cond_true) begin
      tgt_next = br_rel ? (pc + disp_sx) : target;
    end
  end

endmodule : pc_target_calc

// File: rtl/pc_unit.sv
// Program-counter datapath: PC/link registers, two-phase jump arm/commit, memory address mux.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = PC_ADDR_W,
  parameter int                DISP_W   = PC_DISP_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCe,
  input  logic              npc_ctrl,
  input  logic              mem_pc_ctrl,
  input  logic              Lscntl,
  input  logic              cond_true,
  input  logic              br_rel,
  input  logic [ADDR_W-1:0] target,
  input  logic [DISP_W-1:0] disp,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] link_bus,
  output logic              jmp_armed
);

  pc_state_t         state, state_d;
  logic [ADDR_W-1:0] link, link_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc, tgt_next;

  pc_target_calc #(
    .ADDR_W (ADDR_W),
    .DISP_W (DISP_W)
  ) u_calc (
    .pc        (pc),
    .target    (target),
    .disp      (disp),
    .cond_true (cond_true),
    .br_rel    (br_rel),
    .pc_inc    (pc_inc),
    .tgt_next  (tgt_next)
  );

  // State and datapath registers; reset discards any armed target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      link  <= '0;
      tgt_q <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      link  <= link_d;
      tgt_q <= tgt_d;
    end
  end

  // Next-state and register updates; both states re-arm on (PCe,npc)=(1,1).
  always_comb begin
    state_d = state;
    pc_d    = pc;
    link_d  = link;
    tgt_d   = tgt_q;
    if (PCe) begin
      if (npc_ctrl) begin
        link_d  = pc_inc;
        tgt_d   = tgt_next;
        state_d = ARMED;
      end else if (state == ARMED) begin
        pc_d    = tgt_q;
        state_d = IDLE;
      end else begin
        pc_d    = pc_inc;
      end
    end
  end

  // Output muxes: memory address source, link writeback, armed flag.
  always_comb begin
    mem_addr  = Lscntl ? pc : ls_addr;
    link_bus  = mem_pc_ctrl ? link : '0;
    jmp_armed = (state == ARMED);
  end

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: expectations queued at stimulus time, compared on sampling.
module tb_pc_unit;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          PCe = 1'b0, npc_ctrl = 1'b0, mem_pc_ctrl = 1'b0, Lscntl = 1'b1;
  logic          cond_true = 1'b1, br_rel = 1'b0;
  logic [AW-1:0] target = '0, ls_addr = '0;
  logic [DW-1:0] disp = '0;
  logic [AW-1:0] pc, mem_addr, link_bus;
  logic          jmp_armed;

  pc_unit #(.ADDR_W(AW), .DISP_W(DW), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCe         (PCe),
    .npc_ctrl    (npc_ctrl),
    .mem_pc_ctrl (mem_pc_ctrl),
    .Lscntl      (Lscntl),
    .cond_true   (cond_true),
    .br_rel      (br_rel),
    .target      (target),
    .disp        (disp),
    .ls_addr     (ls_addr),
    .pc          (pc),
    .mem_addr    (mem_addr),
    .link_bus    (link_bus),
    .jmp_armed   (jmp_armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;   // 0 pc, 1 jmp_armed, 2 mem_addr, 3 link_bus
    logic [AW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic [AW-1:0] m_pc = '0, m_link = '0, m_tgt = '0;
  logic          m_armed = 1'b0;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [AW-1:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [AW-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = pc;
        1:       obs = {{(AW-1){1'b0}}, jmp_armed};
        2:       obs = mem_addr;
        default: obs = link_bus;
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  // One clock: drive strobes at negedge, advance model, compare after posedge.
  task automatic cyc(input logic pce, input logic npc, input string tag);
    logic [AW-1:0] inc, tg;
    @(negedge clk);
    PCe = pce; npc_ctrl = npc;
    inc = m_pc + 16'd1;
    tg  = !cond_true ? inc : (br_rel ? m_pc + {{(AW-DW){disp[DW-1]}}, disp} : target);
    if (!reset) begin
      m_pc = '0; m_link = '0; m_tgt = '0; m_armed = 1'b0;
    end else if (pce && npc) begin
      m_link = inc; m_tgt = tg; m_armed = 1'b1;
    end else if (pce && m_armed) begin
      m_pc = m_tgt; m_armed = 1'b0;
    end else if (pce) begin
      m_pc = inc;
    end
    expect_val({tag, ".pc"}, 0, m_pc);
    expect_val({tag, ".armed"}, 1, {15'd0, m_armed});
    @(posedge clk);
    #1;
    drain();
    PCe = 1'b0; npc_ctrl = 1'b0;
  endtask

  task automatic comb(input string tag, input int sel, input logic [AW-1:0] val);
    expect_val(tag, sel, val);
    #1;
    drain();
  endtask

  task automatic jump_abs(input logic [AW-1:0] t, input string tag);
    cond_true = 1'b1; br_rel = 1'b0; target = t;
    cyc(1, 1, {tag, ".arm"});
    cyc(0, 1, {tag, ".dwell"});
    cyc(1, 0, {tag, ".commit"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    comb("rst.pc", 0, 16'h0000);
    comb("rst.armed", 1, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Increment and wrap
    jump_abs(16'h0010, "to10");
    cyc(1, 0, "inc");
    comb("inc.val", 0, 16'h0011);
    jump_abs(16'hFFFF, "toFFFF");
    cyc(1, 0, "wrap");
    comb("wrap.val", 0, 16'h0000);

    // Absolute jump with input change during dwell
    jump_abs(16'h0020, "to20");
    mem_pc_ctrl = 1'b1;
    comb("lb.old", 3, m_link);
    target = 16'h0100;
    cyc(1, 1, "abs.arm");
    comb("abs.lb", 3, 16'h0021);
    comb("abs.armed1", 1, 16'h0001);
    target = 16'h7777;
    cyc(0, 1, "abs.dwell");
    comb("abs.armed2", 1, 16'h0001);
    cyc(1, 0, "abs.commit");
    comb("abs.pc", 0, 16'h0100);
    comb("abs.armed0", 1, 16'h0000);
    mem_pc_ctrl = 1'b0;
    comb("lb.off", 3, 16'h0000);

    // Relative branch taken / not taken
    jump_abs(16'h0040, "to40");
    br_rel = 1'b1; disp = 8'hF0; cond_true = 1'b1;
    cyc(1, 1, "rel.arm"); cyc(0, 1, "rel.dwell"); cyc(1, 0, "rel.commit");
    comb("rel.pc", 0, 16'h0030);
    jump_abs(16'h0040, "to40b");
    br_rel = 1'b1; disp = 8'hF0; cond_true = 1'b0;
    cyc(1, 1, "nt.arm"); cyc(0, 1, "nt.dwell"); cyc(1, 0, "nt.commit");
    comb("nt.pc", 0, 16'h0041);
    cond_true = 1'b1; br_rel = 1'b0;

    // npc alone in IDLE ignored; re-arm while ARMED
    cyc(0, 1, "npc.idle");
    target = 16'h0300; cyc(1, 1, "re.arm1");
    target = 16'h0400; cyc(1, 1, "re.arm2");
    cyc(1, 0, "re.commit");
    comb("re.pc", 0, 16'h0400);

    // Memory address mux
    Lscntl = 1'b0; ls_addr = 16'h0ABC;
    comb("ma.ls", 2, 16'h0ABC);
    Lscntl = 1'b1;
    comb("ma.pc", 2, 16'h0400);

    // Reset mid-run with PCe pulses
    mem_pc_ctrl = 1'b1;
    reset = 1'b0;
    comb("r1.pc", 0, 16'h0000);
    comb("r1.lb", 3, 16'h0000);
    cyc(1, 0, "r1.p1"); cyc(1, 1, "r1.p2");
    @(negedge clk); reset = 1'b1;
    cyc(0, 0, "r1.hold");
    mem_pc_ctrl = 1'b0;

    // Reset while ARMED
    jump_abs(16'h0050, "to50");
    target = 16'h0200; cyc(1, 1, "r6.arm");
    reset = 1'b0;
    comb("r6.pc", 0, 16'h0000);
    comb("r6.armed", 1, 16'h0000);
    m_pc = '0; m_link = '0; m_tgt = '0; m_armed = 1'b0;
    @(negedge clk); reset = 1'b1;
    cyc(1, 0, "r6.inc");
    comb("r6.val", 0, 16'h0001);

    // Random strobe sequences against the model
    for (int i = 0; i < 60; i++) begin
      target = 16'($urandom); disp = 8'($urandom);
      cond_true = 1'($urandom); br_rel = 1'($urandom);
      cyc(1'($urandom), 1'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pc_unit
